// File: rtl/snn_window_scheduler.sv
// snn_window_scheduler: sequences a bank of integrate-and-fire neurons through encode/integrate/fire windows.
// Build option: define SNN_SCHED_REFRACT_EN to include per-neuron refractory counters.
module snn_window_scheduler #(
    parameter int                 N_NEURONS   = 4,
    parameter int                 T_WINDOW    = 250,
    parameter int                 ENCODE_TIME = 23,
    parameter logic signed [15:0] THRESHOLD   = 16'sh2710,
    parameter int                 REFRACT     = 2,
    localparam int                IDXW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    output logic                   busy,
    output logic                   enc_en,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IDXW-1:0]        req_idx,
    input  logic signed [15:0]     req_weight,
    output logic [N_NEURONS-1:0]   spike_vec,
    output logic                   spike_valid,
    output logic [15:0]            window_cnt,
    output logic                   err_idx
);

    localparam int DATA_W = 16;
    localparam int TW     = (T_WINDOW > 2) ? $clog2(T_WINDOW) : 1;

    localparam logic [TW-1:0] ENC_LAST   = TW'(ENCODE_TIME - 1);
    localparam logic [TW-1:0] INT_LAST   = TW'(T_WINDOW - N_NEURONS - 1);
    localparam logic [TW-1:0] FIRE_START = TW'(T_WINDOW - N_NEURONS);
    localparam logic [TW-1:0] T_LAST     = TW'(T_WINDOW - 1);

    localparam logic signed [DATA_W-1:0] POT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] POT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    generate
        if (T_WINDOW <= ENCODE_TIME + N_NEURONS || ENCODE_TIME < 1 || REFRACT < 0) begin : g_bad_cfg
            $error("snn_window_scheduler: need T_WINDOW > ENCODE_TIME + N_NEURONS, ENCODE_TIME >= 1, REFRACT >= 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ENCODE    = 2'd1,
        INTEGRATE = 2'd2,
        FIRE      = 2'd3
    } state_t;

    state_t                    state, state_nxt;
    logic [TW-1:0]             t;
    logic                      stop_seen;
    logic signed [DATA_W-1:0]  pot [N_NEURONS];
    logic [N_NEURONS-1:0]      spike_acc, spike_acc_nxt;
    logic [IDXW-1:0]           fire_idx;
    logic                      window_end;
    logic                      accept;
    logic                      idx_ok;
    logic                      evt_blocked;
    logic                      fire_blocked;
    logic                      fire_hit;

    // Adds with clamping to the signed 16-bit range instead of wrapping.
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W:0] sum;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (sum[DATA_W] != sum[DATA_W-1])
            return sum[DATA_W] ? POT_MIN : POT_MAX;
        return sum[DATA_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = ENCODE;
            ENCODE:    if (t == ENC_LAST) state_nxt = INTEGRATE;
            INTEGRATE: if (t == INT_LAST) state_nxt = FIRE;
            FIRE:      if (t == T_LAST) state_nxt = (stop_seen || stop) ? IDLE : ENCODE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        enc_en    = (state == ENCODE);
        req_ready = (state == INTEGRATE);
    end

    always_comb begin
        window_end = (state == FIRE) && (t == T_LAST);
        accept     = req_valid && (state == INTEGRATE);
        idx_ok     = (int'(req_idx) < N_NEURONS);
        fire_idx   = IDXW'(t - FIRE_START);
    end

`ifdef SNN_SCHED_REFRACT_EN
    localparam int RW = (REFRACT > 1) ? $clog2(REFRACT + 1) : 1;

    logic [RW-1:0] refr [N_NEURONS];

    always_comb begin
        evt_blocked  = (refr[req_idx] != '0);
        fire_blocked = (refr[fire_idx] != '0);
    end

    // A firing neuron reloads its counter; otherwise each FIRE visit counts it down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_NEURONS; i++) refr[i] <= '0;
        end else if (state == IDLE) begin
            if (start)
                for (int i = 0; i < N_NEURONS; i++) refr[i] <= '0;
        end else if (state == FIRE) begin
            if (fire_hit)
                refr[fire_idx] <= RW'(REFRACT);
            else if (refr[fire_idx] != '0)
                refr[fire_idx] <= refr[fire_idx] - 1'b1;
        end
    end
`else
    always_comb begin
        evt_blocked  = 1'b0;
        fire_blocked = 1'b0;
    end
`endif

    always_comb begin
        fire_hit      = (state == FIRE) && !fire_blocked && (pot[fire_idx] >= THRESHOLD);
        spike_acc_nxt = spike_acc;
        if (fire_hit)
            spike_acc_nxt[fire_idx] = 1'b1;
    end

    // Window bookkeeping: phase counter, pending stop, spike assembly and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t           <= '0;
            stop_seen   <= 1'b0;
            spike_acc   <= '0;
            spike_vec   <= '0;
            spike_valid <= 1'b0;
            window_cnt  <= '0;
            err_idx     <= 1'b0;
        end else begin
            spike_valid <= 1'b0;
            if (state == IDLE) begin
                t         <= '0;
                stop_seen <= 1'b0;
                spike_acc <= '0;
                spike_vec <= '0;
                if (start) begin
                    window_cnt <= '0;
                    err_idx    <= 1'b0;
                end
            end else begin
                t         <= window_end ? '0 : t + 1'b1;
                spike_acc <= window_end ? '0 : spike_acc_nxt;
                if (stop)
                    stop_seen <= 1'b1;
                if (accept && !idx_ok)
                    err_idx <= 1'b1;
                if (window_end) begin
                    spike_vec   <= spike_acc_nxt;
                    spike_valid <= 1'b1;
                    window_cnt  <= window_cnt + 16'd1;
                    stop_seen   <= 1'b0;
                end
            end
        end
    end

    // Integration and fire reset never coincide: they live in different states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_NEURONS; i++) pot[i] <= '0;
        end else if (state == IDLE) begin
            if (start)
                for (int i = 0; i < N_NEURONS; i++) pot[i] <= '0;
        end else if (accept && idx_ok && !evt_blocked) begin
            pot[req_idx] <= sat_add(pot[req_idx], req_weight);
        end else if (fire_hit) begin
            pot[fire_idx] <= '0;
        end
    end

endmodule

// File: tb/tb_snn_window_scheduler.sv
// Bench for snn_window_scheduler: directed and randomized windows checked against a window-level model.
`timescale 1ns/1ps
module tb_snn_window_scheduler;

    localparam int N   = 4;
    localparam int TW  = 250;
    localparam int ENC = 23;
    localparam int TH  = 10000;
    localparam int RF  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, stop, req_valid;
    logic [1:0]         req_idx;
    logic signed [15:0] req_weight;
    logic               busy, enc_en, req_ready, spike_valid, err_idx;
    logic [3:0]         spike_vec;
    logic [15:0]        window_cnt;

    logic               b_start, b_stop, b_req_valid;
    logic [2:0]         b_req_idx;
    logic signed [15:0] b_req_weight;
    logic               b_busy, b_enc_en, b_req_ready, b_spike_valid, b_err_idx;
    logic [4:0]         b_spike_vec;
    logic [15:0]        b_window_cnt;

    snn_window_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .busy(busy), .enc_en(enc_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_weight(req_weight),
        .spike_vec(spike_vec), .spike_valid(spike_valid), .window_cnt(window_cnt), .err_idx(err_idx)
    );

    snn_window_scheduler #(.N_NEURONS(5)) dut5 (
        .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .busy(b_busy), .enc_en(b_enc_en),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_idx(b_req_idx), .req_weight(b_req_weight),
        .spike_vec(b_spike_vec), .spike_valid(b_spike_valid), .window_cnt(b_window_cnt), .err_idx(b_err_idx)
    );

    int checks = 0;
    int failures = 0;

    int m_pot [N];
    int m_refr [N];
    bit m_err;
    int m_wcnt;

    bit ev_v [TW];
    int ev_i [TW];
    int ev_w [TW];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_pot[k]  = 0;
            m_refr[k] = 0;
        end
        m_err  = 1'b0;
        m_wcnt = 0;
    endtask

    task automatic model_event(input int idx, input int w);
        bit blocked;
        if (idx >= N) begin
            m_err = 1'b1;
            return;
        end
`ifdef SNN_SCHED_REFRACT_EN
        blocked = (m_refr[idx] != 0);
`else
        blocked = 1'b0;
`endif
        if (!blocked) m_pot[idx] = sat(m_pot[idx] + w);
    endtask

    function automatic bit [N-1:0] model_fire();
        bit [N-1:0] v = '0;
        for (int k = 0; k < N; k++) begin
`ifdef SNN_SCHED_REFRACT_EN
            if (m_refr[k] == 0 && m_pot[k] >= TH) begin
                v[k] = 1'b1; m_pot[k] = 0; m_refr[k] = RF;
            end else if (m_refr[k] > 0) begin
                m_refr[k]--;
            end
`else
            if (m_pot[k] >= TH) begin
                v[k] = 1'b1; m_pot[k] = 0;
            end
`endif
        end
        return v;
    endfunction

    task automatic clear_events();
        for (int c = 0; c < TW; c++) begin
            ev_v[c] = 1'b0; ev_i[c] = 0; ev_w[c] = 0;
        end
    endtask

    task automatic add_event(input int c, input int idx, input int w);
        ev_v[c] = 1'b1; ev_i[c] = idx; ev_w[c] = w;
    endtask

    task automatic rand_events(input int pct, input int lo, input int hi);
        for (int c = 0; c < TW; c++) begin
            ev_v[c] = ($urandom_range(0, 99) < pct);
            ev_i[c] = int'($urandom_range(0, N - 1));
            ev_w[c] = lo + int'($urandom_range(0, hi - lo));
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
    endtask

    // Called in cycle t=0 of a window (1ns after the edge); returns 1ns after the closing edge.
    task automatic run_window(input string tag, input int ncyc, input int stop_at, input int start_at);
        int enc_cnt = 0, rdy_cnt = 0, busy_bad = 0, sv_bad = 0, phase_bad = 0;
        bit [N-1:0] exp_vec;
        for (int c = 0; c < ncyc; c++) begin
            if (enc_en === 1'b1) enc_cnt++;
            if (req_ready === 1'b1) rdy_cnt++;
            if (busy !== 1'b1) busy_bad++;
            if (c > 0 && spike_valid !== 1'b0) sv_bad++;
            if (enc_en !== (c < ENC)) phase_bad++;
            if (req_ready !== (c >= ENC && c < TW - N)) phase_bad++;
            req_valid  = ev_v[c];
            req_idx    = ev_i[c][1:0];
            req_weight = ev_w[c][15:0];
            stop       = (c == stop_at);
            start      = (c == start_at);
            if (ev_v[c] && c >= ENC && c < TW - N) model_event(ev_i[c], ev_w[c]);
            @(posedge clk); #1;
            req_valid = 1'b0; stop = 1'b0; start = 1'b0;
        end
        check({tag, ".busy_in_window"}, busy_bad, 0);
        check({tag, ".phase_outputs"}, phase_bad, 0);
        check({tag, ".no_early_spike_valid"}, sv_bad, 0);
        if (ncyc == TW) begin
            exp_vec = model_fire();
            m_wcnt  = (m_wcnt + 1) & 16'hFFFF;
            check({tag, ".enc_cycles"}, enc_cnt, ENC);
            check({tag, ".ready_cycles"}, rdy_cnt, TW - ENC - N);
            check({tag, ".spike_valid"}, spike_valid, 1);
            check({tag, ".spike_vec"}, spike_vec, exp_vec);
            check({tag, ".window_cnt"}, window_cnt, m_wcnt);
            check({tag, ".err_idx"}, err_idx, m_err);
            check({tag, ".busy_at_end"}, busy, (stop_at >= 0) ? 0 : 1);
        end
    endtask

    initial begin
        int bad;
        bit got;
        logic [4:0] b_vec;
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        req_valid = 1'b0; req_idx = '0; req_weight = '0;
        b_start = 1'b0; b_stop = 1'b0; b_req_valid = 1'b0; b_req_idx = '0; b_req_weight = '0;
        model_clear();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.enc_en", enc_en, 0);
        check("rst.req_ready", req_ready, 0);
        check("rst.spike_vec", spike_vec, 0);
        check("rst.spike_valid", spike_valid, 0);
        check("rst.window_cnt", window_cnt, 0);
        check("rst.err_idx", err_idx, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle.busy", busy, 0);

        // Empty first window
        do_start();
        check("start.busy", busy, 1);
        check("start.enc_en", enc_en, 1);
        clear_events();
        run_window("w_empty", TW, -1, -1);

        // Single threshold-level event to neuron 2, repeated over four windows
        clear_events();
        add_event(50, 2, 16'sh2710);
        for (int w = 0; w < 4; w++) run_window($sformatf("w_n2_%0d", w), TW, -1, -1);

        // Positive saturation then negative saturation on neuron 0
        clear_events();
        for (int i = 0; i < 3; i++) add_event(30 + i, 0, 28672);
        run_window("w_sat_pos", TW, -1, -1);
        clear_events();
        for (int i = 0; i < 4; i++) add_event(30 + i, 0, -28672);
        run_window("w_sat_neg", TW, -1, -1);

        // Exactly-at-threshold via back-to-back events, and one below threshold
        clear_events();
        add_event(100, 3, 5000);
        add_event(101, 3, 5000);
        add_event(102, 1, 9999);
        add_event(22, 1, 20000);
        add_event(246, 1, 20000);
        run_window("w_edge", TW, -1, -1);

        // Randomized windows, one with an ignored start pulse
        for (int w = 0; w < 6; w++) begin
            rand_events(40, -20000, 20000);
            run_window($sformatf("w_rand_%0d", w), TW, -1, (w == 2) ? 120 : -1);
        end

        // Stop mid-window, then idle with req_valid held
        rand_events(40, -20000, 20000);
        run_window("w_stop", TW, 100, -1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            req_valid = 1'b1; req_idx = 2'd0; req_weight = 16'sh7fff;
            stop = (c == 5);
            @(posedge clk); #1;
            stop = 1'b0;
            if (busy !== 1'b0 || req_ready !== 1'b0 || enc_en !== 1'b0 || spike_valid !== 1'b0) bad++;
        end
        req_valid = 1'b0;
        check("idle.outputs_quiet", bad, 0);
        check("idle.spike_vec", spike_vec, 0);
        check("idle.window_cnt_holds", window_cnt, m_wcnt);

        // start and stop together from IDLE: start wins and the window runs normally
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        model_clear();
        check("startstop.busy", busy, 1);
        rand_events(50, -15000, 20000);
        run_window("w_startstop", TW, -1, -1);

        // Asynchronous reset in the middle of a window with charged potentials
        rand_events(60, 2000, 9000);
        run_window("w_pre_rst", 150, -1, -1);
        #2 rst = 1'b0;
        #1;
        check("midrst.busy", busy, 0);
        check("midrst.enc_en", enc_en, 0);
        check("midrst.req_ready", req_ready, 0);
        check("midrst.spike_vec", spike_vec, 0);
        check("midrst.spike_valid", spike_valid, 0);
        check("midrst.window_cnt", window_cnt, 0);
        check("midrst.err_idx", err_idx, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        bad = 0;
        for (int c = 0; c < TW + 10; c++) begin
            @(posedge clk); #1;
            if (spike_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("midrst.no_pulse", bad, 0);
        do_start();
        clear_events();
        run_window("w_post_rst", TW, -1, -1);
        clear_events();
        add_event(60, 0, 9999);
        run_window("w_post_rst2", TW, -1, -1);

        // Out-of-range index on a 5-neuron instance
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        check("oor.busy", b_busy, 1);
        repeat (ENC + 5) @(posedge clk);
        #1;
        b_req_valid = 1'b1; b_req_idx = 3'd5; b_req_weight = 16'sh7fff;
        @(posedge clk); #1;
        b_req_idx = 3'd7;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        check("oor.err_idx_set", b_err_idx, 1);
        b_stop = 1'b1;
        @(posedge clk); #1;
        b_stop = 1'b0;
        got = 1'b0;
        b_vec = '0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            if (b_spike_valid === 1'b1) begin
                got = 1'b1;
                b_vec = b_spike_vec;
            end
        end
        check("oor.window_done", got, 1);
        check("oor.spike_vec", b_vec, 0);
        check("oor.window_cnt", b_window_cnt, 1);
        check("oor.busy_dropped", b_busy, 0);
        check("oor.err_idx_sticky", b_err_idx, 1);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        check("oor.err_idx_cleared", b_err_idx, 0);
        check("oor.window_cnt_cleared", b_window_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
